// File: rtl/de_stage.sv
// -----------------------------------------------------------------------------
// de_stage -- decode stage of the RV32I five-stage pipeline (IF -> DE -> ALU).
//
// Holds the IF->DE pipeline register, decodes the instruction, hands rs1/rs2
// read addresses to the forwarding unit, takes the forwarded operands back
// and launches a fully decoded, operand-resolved instruction into the
// DE->ALU pipeline register.
//
// Handshake: on both the IF->DE boundary (IF_Valid_1 / DE_Allowin_1) and the
// DE->ALU boundary (ALU_Valid_1 / ALU_Allowin_1) an instruction moves on a
// rising clk edge where the producer's valid and the consumer's allowin are
// both high. Valid never depends on allowin; allowin may depend on valid.
//
// Ports:
//   clk, resetn                    clock (rising edge), synchronous active-low reset
//   IF_Valid_1, IF_PC_32,
//   IF_Inst_32                     fetched instruction from IF
//   DE_Allowin_1                   DE register can accept from IF this cycle
//   DE_GRFReadAddr1_5/2_5          rs1/rs2 to forwarding unit (0 when unused)
//   DE_GRFReadData1_32/2_32        forwarded rs1/rs2 values
//   WaitLoad_1                     load-use hazard from forwarding unit
//   ALU_Allowin_1                  execute stage can accept
//   ALU_Flush_1                    taken branch/jump in execute, kill younger
//   ALU_*                          DE->ALU pipeline register contents
// -----------------------------------------------------------------------------
module de_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_Valid_1,
    input  logic [31:0] IF_PC_32,
    input  logic [31:0] IF_Inst_32,
    output logic        DE_Allowin_1,
    output logic [4:0]  DE_GRFReadAddr1_5,
    output logic [4:0]  DE_GRFReadAddr2_5,
    input  logic [31:0] DE_GRFReadData1_32,
    input  logic [31:0] DE_GRFReadData2_32,
    input  logic        WaitLoad_1,
    input  logic        ALU_Allowin_1,
    input  logic        ALU_Flush_1,
    output logic        ALU_Valid_1,
    output logic [31:0] ALU_PC_32,
    output logic [31:0] ALU_Rs1Data_32,
    output logic [31:0] ALU_Rs2Data_32,
    output logic [31:0] ALU_Imm_32,
    output logic [3:0]  ALU_InstType_4,
    output logic [2:0]  ALU_Funct3_3,
    output logic        ALU_Funct7b5_1,
    output logic [4:0]  ALU_GRFWriteAddr_5,
    output logic        ALU_GRFWen_1,
    output logic        ALU_Load_1
);

    localparam logic [3:0] TYPE_OP      = 4'd0;
    localparam logic [3:0] TYPE_OPIMM   = 4'd1;
    localparam logic [3:0] TYPE_LOAD    = 4'd2;
    localparam logic [3:0] TYPE_STORE   = 4'd3;
    localparam logic [3:0] TYPE_BRANCH  = 4'd4;
    localparam logic [3:0] TYPE_JAL     = 4'd5;
    localparam logic [3:0] TYPE_JALR    = 4'd6;
    localparam logic [3:0] TYPE_LUI     = 4'd7;
    localparam logic [3:0] TYPE_AUIPC   = 4'd8;
    localparam logic [3:0] TYPE_ILLEGAL = 4'd15;

    // ------------------------------------------------------------------
    // IF -> DE register
    // ------------------------------------------------------------------
    logic        deValid;
    logic [31:0] dePC;
    logic [31:0] deInst;
    logic        deReadyGo;

    assign deReadyGo    = ~WaitLoad_1;
    assign DE_Allowin_1 = ~deValid | (deReadyGo & ALU_Allowin_1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            deValid <= 1'b0;
            dePC    <= RESET_PC;
            deInst  <= NOP_INST;
        end else if (ALU_Flush_1) begin
            deValid <= 1'b0;
            deInst  <= NOP_INST;
        end else if (DE_Allowin_1) begin
            deValid <= IF_Valid_1;
            // PC/Inst only move with a real instruction so an idle DE keeps
            // a harmless word rather than whatever IF happens to present.
            if (IF_Valid_1) begin
                dePC   <= IF_PC_32;
                deInst <= IF_Inst_32;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immB;
    logic [31:0] immU;
    logic [31:0] immJ;

    assign opcode = deInst[6:0];
    assign rd     = deInst[11:7];
    assign funct3 = deInst[14:12];
    assign rs1    = deInst[19:15];
    assign rs2    = deInst[24:20];

    assign immI = {{20{deInst[31]}}, deInst[31:20]};
    assign immS = {{20{deInst[31]}}, deInst[31:25], deInst[11:7]};
    assign immB = {{19{deInst[31]}}, deInst[31], deInst[7], deInst[30:25], deInst[11:8], 1'b0};
    assign immU = {deInst[31:12], 12'b0};
    assign immJ = {{11{deInst[31]}}, deInst[31], deInst[19:12], deInst[20], deInst[30:21], 1'b0};

    logic [3:0]  decType;
    logic [31:0] decImm;
    logic        useRs1;
    logic        useRs2;
    logic        writesRd;
    logic        decWen;
    logic        decLoad;
    logic        decF7b5;

    always_comb begin
        decType  = TYPE_ILLEGAL;
        decImm   = 32'd0;
        useRs1   = 1'b0;
        useRs2   = 1'b0;
        writesRd = 1'b0;
        case (opcode)
            7'b0110011: begin decType = TYPE_OP;     useRs1 = 1'b1; useRs2 = 1'b1; writesRd = 1'b1; end
            7'b0010011: begin decType = TYPE_OPIMM;  decImm = immI; useRs1 = 1'b1; writesRd = 1'b1; end
            7'b0000011: begin decType = TYPE_LOAD;   decImm = immI; useRs1 = 1'b1; writesRd = 1'b1; end
            7'b0100011: begin decType = TYPE_STORE;  decImm = immS; useRs1 = 1'b1; useRs2 = 1'b1; end
            7'b1100011: begin decType = TYPE_BRANCH; decImm = immB; useRs1 = 1'b1; useRs2 = 1'b1; end
            7'b1101111: begin decType = TYPE_JAL;    decImm = immJ; writesRd = 1'b1; end
            7'b1100111: begin decType = TYPE_JALR;   decImm = immI; useRs1 = 1'b1; writesRd = 1'b1; end
            7'b0110111: begin decType = TYPE_LUI;    decImm = immU; writesRd = 1'b1; end
            7'b0010111: begin decType = TYPE_AUIPC;  decImm = immU; writesRd = 1'b1; end
            default:    begin decType = TYPE_ILLEGAL; end
        endcase
    end

    assign decWen  = writesRd & (rd != 5'd0);
    assign decLoad = (decType == TYPE_LOAD);
    // inst[30] only carries meaning for OP (add/sub, srl/sra) and OP-IMM
    // right shifts (srli/srai); elsewhere it is immediate bits.
    assign decF7b5 = ((decType == TYPE_OP) ||
                      ((decType == TYPE_OPIMM) && (funct3 == 3'b101))) ? deInst[30] : 1'b0;

    // Unused or invalid reads are forced to x0 so the forwarding unit never
    // raises a false load-use hazard or forwards against a stale field.
    assign DE_GRFReadAddr1_5 = (deValid && useRs1) ? rs1 : 5'd0;
    assign DE_GRFReadAddr2_5 = (deValid && useRs2) ? rs2 : 5'd0;

    // ------------------------------------------------------------------
    // DE -> ALU register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ALU_Valid_1        <= 1'b0;
            ALU_PC_32          <= 32'd0;
            ALU_Rs1Data_32     <= 32'd0;
            ALU_Rs2Data_32     <= 32'd0;
            ALU_Imm_32         <= 32'd0;
            ALU_InstType_4     <= TYPE_ILLEGAL;
            ALU_Funct3_3       <= 3'd0;
            ALU_Funct7b5_1     <= 1'b0;
            ALU_GRFWriteAddr_5 <= 5'd0;
            ALU_GRFWen_1       <= 1'b0;
            ALU_Load_1         <= 1'b0;
        end else if (ALU_Allowin_1 || ALU_Flush_1) begin
            if (!ALU_Flush_1 && deValid && deReadyGo) begin
                ALU_Valid_1        <= 1'b1;
                ALU_PC_32          <= dePC;
                ALU_Rs1Data_32     <= DE_GRFReadData1_32;
                ALU_Rs2Data_32     <= DE_GRFReadData2_32;
                ALU_Imm_32         <= decImm;
                ALU_InstType_4     <= decType;
                ALU_Funct3_3       <= funct3;
                ALU_Funct7b5_1     <= decF7b5;
                ALU_GRFWriteAddr_5 <= rd;
                ALU_GRFWen_1       <= decWen;
                ALU_Load_1         <= decLoad;
            end else begin
                // Bubble: GRFWen/Load must be low because the forwarding
                // unit looks at them without qualifying by valid.
                ALU_Valid_1        <= 1'b0;
                ALU_PC_32          <= 32'd0;
                ALU_Rs1Data_32     <= 32'd0;
                ALU_Rs2Data_32     <= 32'd0;
                ALU_Imm_32         <= 32'd0;
                ALU_InstType_4     <= TYPE_ILLEGAL;
                ALU_Funct3_3       <= 3'd0;
                ALU_Funct7b5_1     <= 1'b0;
                ALU_GRFWriteAddr_5 <= 5'd0;
                ALU_GRFWen_1       <= 1'b0;
                ALU_Load_1         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_de_stage.sv
module tb_de_stage;

  localparam int W = 143;
  localparam logic [31:0] D1  = 32'h1111_1111;
  localparam logic [31:0] D2  = 32'h2222_2222;
  localparam logic [31:0] FWD = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        de_allowin;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wait_load;
  logic        alu_allowin;
  logic        alu_flush;
  logic        alu_valid;
  logic [31:0] alu_pc;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_imm;
  logic [3:0]  alu_type;
  logic [2:0]  alu_f3;
  logic        alu_f7b5;
  logic [4:0]  alu_waddr;
  logic        alu_wen;
  logic        alu_load;

  de_stage dut (
    .clk                (clk),
    .resetn             (resetn),
    .IF_Valid_1         (if_valid),
    .IF_PC_32           (if_pc),
    .IF_Inst_32         (if_inst),
    .DE_Allowin_1       (de_allowin),
    .DE_GRFReadAddr1_5  (rd_addr1),
    .DE_GRFReadAddr2_5  (rd_addr2),
    .DE_GRFReadData1_32 (rd_data1),
    .DE_GRFReadData2_32 (rd_data2),
    .WaitLoad_1         (wait_load),
    .ALU_Allowin_1      (alu_allowin),
    .ALU_Flush_1        (alu_flush),
    .ALU_Valid_1        (alu_valid),
    .ALU_PC_32          (alu_pc),
    .ALU_Rs1Data_32     (alu_rs1),
    .ALU_Rs2Data_32     (alu_rs2),
    .ALU_Imm_32         (alu_imm),
    .ALU_InstType_4     (alu_type),
    .ALU_Funct3_3       (alu_f3),
    .ALU_Funct7b5_1     (alu_f7b5),
    .ALU_GRFWriteAddr_5 (alu_waddr),
    .ALU_GRFWen_1       (alu_wen),
    .ALU_Load_1         (alu_load)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic take = 1'b0;

  function automatic logic [W-1:0] pack(input logic [31:0] pc, input logic [31:0] rs1d,
                                        input logic [31:0] rs2d, input logic [31:0] imm,
                                        input logic [3:0] typ, input logic [2:0] f3,
                                        input logic f7b5, input logic [4:0] wa,
                                        input logic wen, input logic ld);
    return {pc, rs1d, rs2d, imm, typ, f3, f7b5, wa, wen, ld};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // An edge with ALU_Allowin or Flush high refreshes the ALU register; a
  // valid value seen after such an edge is a newly issued instruction.
  always @(posedge clk) take <= alu_allowin | alu_flush;

  always @(negedge clk) begin
    if (take && alu_valid) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed issue of pc %0h, expected none", alu_pc);
      end
      if (exp_q.size() != 0)
        check("sb_issue", pack(alu_pc, alu_rs1, alu_rs2, alu_imm, alu_type, alu_f3,
                               alu_f7b5, alu_waddr, alu_wen, alu_load), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn      = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    rd_data1    = D1;
    rd_data2    = D2;
    wait_load   = 1'b0;
    alu_allowin = 1'b1;
    alu_flush   = 1'b0;
    step();
    step();

    // Reset state
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_type", alu_type, 15);
    check("rst_alu_payload", pack(alu_pc, alu_rs1, alu_rs2, alu_imm, 4'd0, alu_f3,
                                  alu_f7b5, alu_waddr, alu_wen, alu_load), 0);
    check("rst_de_allowin", de_allowin, 1);
    check("rst_rd_addr1", rd_addr1, 0);
    check("rst_rd_addr2", rd_addr2, 0);

    // addi x1,x0,5
    resetn = 1'b1;
    drive(1'b1, 32'h100, 32'h0050_0093);
    exp_q.push_back(pack(32'h100, D1, D2, 32'd5, 4'd1, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0));
    step();
    drive(1'b0, 32'd0, 32'd0);
    #1;
    check("addi_rd_addr1", rd_addr1, 0);
    check("addi_rd_addr2", rd_addr2, 0);
    check("addi_not_yet_issued", alu_valid, 0);
    step();

    // lw x2,0(x1) ; add x3,x2,x2 with one load-use stall
    drive(1'b1, 32'h104, 32'h0000_A103);
    exp_q.push_back(pack(32'h104, D1, D2, 32'd0, 4'd2, 3'd2, 1'b0, 5'd2, 1'b1, 1'b1));
    step();
    drive(1'b1, 32'h108, 32'h0021_01B3);
    #1;
    check("lw_rd_addr1", rd_addr1, 1);
    check("lw_rd_addr2", rd_addr2, 0);
    step();
    wait_load = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    #1;
    check("ldu_de_allowin", de_allowin, 0);
    check("add_rd_addr1", rd_addr1, 2);
    check("add_rd_addr2", rd_addr2, 2);
    step();
    check("ldu_bubble", {alu_valid, alu_wen, alu_load, alu_type}, {3'b000, 4'd15});
    wait_load = 1'b0;
    rd_data1  = FWD;
    rd_data2  = FWD;
    exp_q.push_back(pack(32'h108, FWD, FWD, 32'd0, 4'd0, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0));
    step();
    rd_data1 = D1;
    rd_data2 = D2;

    // Backpressure: srai in ALU, sub in DE, ori waiting at IF
    drive(1'b1, 32'h10C, 32'h4030_D213);
    exp_q.push_back(pack(32'h10C, D1, D2, 32'h403, 4'd1, 3'd5, 1'b1, 5'd4, 1'b1, 1'b0));
    step();
    drive(1'b1, 32'h110, 32'h4073_02B3);
    exp_q.push_back(pack(32'h110, D1, D2, 32'd0, 4'd0, 3'd0, 1'b1, 5'd5, 1'b1, 1'b0));
    step();
    drive(1'b1, 32'h114, 32'hFFF0_6413);
    exp_q.push_back(pack(32'h114, D1, D2, 32'hFFFF_FFFF, 4'd1, 3'd6, 1'b0, 5'd8, 1'b1, 1'b0));
    alu_allowin = 1'b0;
    #1;
    check("bp_de_allowin", de_allowin, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_alu_hold", {alu_valid, alu_pc, alu_imm}, {1'b1, 32'h10C, 32'h403});
      check("bp_de_hold", {de_allowin, rd_addr1, rd_addr2}, {1'b0, 5'd6, 5'd7});
    end
    alu_allowin = 1'b1;
    step();
    drive(1'b0, 32'd0, 32'd0);
    step();

    // Flush while DE holds 'and' and IF offers 'xori': both are dropped
    drive(1'b1, 32'h118, 32'h0070_0513);
    exp_q.push_back(pack(32'h118, D1, D2, 32'd7, 4'd1, 3'd0, 1'b0, 5'd10, 1'b1, 1'b0));
    step();
    drive(1'b1, 32'h11C, 32'h0020_F4B3);
    step();
    check("pre_flush_alu_valid", alu_valid, 1);
    drive(1'b1, 32'h120, 32'h0010_4593);
    alu_flush = 1'b1;
    step();
    alu_flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #1;
    check("flush_alu_valid", alu_valid, 0);
    check("flush_rd_addrs", {rd_addr1, rd_addr2}, 0);
    check("flush_de_allowin", de_allowin, 1);
    step();
    check("flush_no_leak", alu_valid, 0);

    // Decode sweep
    drive(1'b1, 32'h200, 32'hFE20_8CE3);  // beq x1,x2,-8
    exp_q.push_back(pack(32'h200, D1, D2, 32'hFFFF_FFF8, 4'd4, 3'd0, 1'b0, 5'd25, 1'b0, 1'b0));
    step();
    drive(1'b1, 32'h204, 32'h1234_5037);  // lui x0,0x12345
    exp_q.push_back(pack(32'h204, D1, D2, 32'h1234_5000, 4'd7, 3'd5, 1'b0, 5'd0, 1'b0, 1'b0));
    #1;
    check("beq_rd_addrs", {rd_addr1, rd_addr2}, {5'd1, 5'd2});
    step();
    drive(1'b1, 32'h208, 32'h0000_0FFF);  // opcode 0x7F, rd=31
    exp_q.push_back(pack(32'h208, D1, D2, 32'd0, 4'd15, 3'd0, 1'b0, 5'd31, 1'b0, 1'b0));
    #1;
    check("lui_rd_addrs", {rd_addr1, rd_addr2}, 0);
    step();
    drive(1'b1, 32'h20C, 32'h0100_00EF);  // jal x1,+16
    exp_q.push_back(pack(32'h20C, D1, D2, 32'd16, 4'd5, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0));
    step();
    drive(1'b1, 32'h210, 32'hFE20_AE23);  // sw x2,-4(x1)
    exp_q.push_back(pack(32'h210, D1, D2, 32'hFFFF_FFFC, 4'd3, 3'd2, 1'b0, 5'd28, 1'b0, 1'b0));
    step();
    drive(1'b0, 32'd0, 32'd0);
    #1;
    check("sw_rd_addrs", {rd_addr1, rd_addr2}, {5'd1, 5'd2});
    step();
    step();

    // Reset with valid instructions in both registers
    drive(1'b1, 32'h300, 32'h00C0_0613);  // addi x12,x0,12
    exp_q.push_back(pack(32'h300, D1, D2, 32'd12, 4'd1, 3'd0, 1'b0, 5'd12, 1'b1, 1'b0));
    step();
    drive(1'b1, 32'h304, 32'h00D0_0693);  // addi x13,x0,13 -- killed by reset
    step();
    drive(1'b0, 32'd0, 32'd0);
    check("pre_rst_alu_valid", alu_valid, 1);
    resetn = 1'b0;
    step();
    check("mid_rst_alu", {alu_valid, alu_wen, alu_load, alu_type}, {3'b000, 4'd15});
    check("mid_rst_de", {de_allowin, rd_addr1, rd_addr2}, {1'b1, 10'd0});
    resetn = 1'b1;
    step();
    check("post_rst_no_issue", alu_valid, 0);
    step();

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
